p5_controller: RTL and testbench
================================

Name: p5_controller

Overview:
- Instruction register, decoder and Moore FSM for the Simple RISC Machine.
- Sits directly upstream of the datapath and drives all of its control inputs, immediates and register numbers.
- Executes MOV-immediate, MOV-register and the four ALU instructions (ADD, CMP, AND, MVN) one state per cycle.
- Signals completion to the top level on `w`.

Parameters:
None (16-bit ISA and 3-bit register numbers are fixed).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s  in  1  start; sampled only in WAIT
- load  in  1  IR load enable
- in  in  16  instruction word
- w  out  1  1 = idle in WAIT, ready for s
- readnum  out  3  register-file read select
- writenum  out  3  register-file write select
- write  out  1  register-file write enable
- loada  out  1  datapath pipeline register A load
- loadb  out  1  datapath pipeline register B load
- loadc  out  1  datapath pipeline register C load
- loads  out  1  datapath status register load
- asel  out  1  1 = Ain forced to 0
- bsel  out  1  1 = Bin from sximm5; always 0 in this block
- vsel  out  2  writeback source select: 00 = C feedback, 01 = sximm8 (10/11 never issued)
- shift  out  2  shifter control = IR[4:3]
- ALUop  out  2  ALU operation select
- sximm5  out  16  sign-extended IR[4:0]
- sximm8  out  16  sign-extended IR[7:0]

Behaviour:
- Reset:
  - Synchronous, active-high: at a posedge with reset=1, state <= WAIT and IR <= 16'h0000.
  - reset overrides load and s.
- Outputs:
  - All outputs are Moore-decoded from the registered state plus IR, so reset is visible on the cycle after the reset edge.
  - In WAIT: w=1 and all load/write strobes are 0.
- IR:
  - IR <= in at a posedge only when load=1 and state==WAIT; load is ignored in every other state.
- IR fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0]
- Immediates: sximm5 and sximm8 are combinational from IR and valid in every state.
- Defaults (every state unless overridden below):
  - All strobes 0, w=0, asel=0, bsel=0, vsel=00.
  - shift = sh; ALUop = op.
  - readnum = writenum = 3'b000.
- States and transitions:
  - WAIT: w=1. If s=1 go to DECODE, else stay.
  - DECODE: no strobes. Next state by instruction:
    - {110,10} (MOV imm) -> WRITE_IMM
    - {110,00} (MOV reg) -> GET_B
    - {101,11} (MVN) -> GET_B
    - {101,00/01/10} -> GET_A
    - any other encoding -> WAIT (illegal; no side effects)
  - WRITE_IMM: writenum=Rn, vsel=01, write=1. Next: WAIT.
  - GET_A: readnum=Rn, loada=1. Next: GET_B.
  - GET_B: readnum=Rm, loadb=1. Next: COMPUTE.
  - COMPUTE:
    - MOV reg: ALUop=00, asel=1.
    - ALU ops: ALUop=op.
    - CMP: loads=1, loadc=0. Next: WAIT.
    - All others: loadc=1, loads=0. Next: WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=00, write=1. Next: WAIT.
- Latency, counted in posedges from the edge that samples s=1 until w=1 again:
  - MOV imm: 3
  - MOV reg, MVN: 5
  - CMP: 5
  - ADD, AND: 6
  - illegal: 2
- Simultaneous events:
  - s=1 and load=1 in the same WAIT cycle: IR captures the new word and DECODE acts on it.
  - s while not in WAIT: ignored (no queuing).
- Reset mid-instruction: the instruction is abandoned, no further write is issued, and the machine returns to WAIT with IR=0.
- Status flags are updated only by CMP.
- State encoding is implementation's choice. No unreachable state may lock up: any unused encoding decodes to WAIT on the next edge.

Test Plan:
1. Reset, load in=16'hD1FE (MOV R1,#-2), pulse s -> WRITE_IMM cycle shows writenum=1, vsel=01, write=1, sximm8=16'hFFFE; w=1 on the 3rd edge after s.
2. Load 16'hA148 (ADD R2,R1,R0,LSL#1), pulse s, check per-cycle strobes:
   - GET_A: readnum=1, loada=1
   - GET_B: readnum=0, loadb=1
   - COMPUTE: shift=01, ALUop=00, loadc=1
   - WRITE_REG: writenum=2, write=1, vsel=00
   - w returns after 6 edges.
3. Load 16'hA900 (CMP R1,R0), pulse s:
   - COMPUTE: loads=1, loadc=0, ALUop=01.
   - write never asserted; w returns after 5 edges.
4. Load 16'hC080 (MOV R4,R0) -> no GET_A; COMPUTE has asel=1, ALUop=00; writenum=4. Load 16'hB860 (MVN R3,R0) -> no GET_A; ALUop=11; writenum=3.
5. Start ADD, then during GET_B: assert load with in=16'hD007 and also pulse s.
   - IR is unchanged (WRITE_REG still targets writenum=2).
   - s is ignored: no re-execution after WAIT.
6. Illegal opcode and mid-instruction reset:
   - Load 16'hE000, pulse s -> DECODE then WAIT, no strobe ever high.
   - Start ADD, assert reset for one cycle in GET_B -> next cycle w=1, all strobes 0, sximm8=16'h0000.

Source files
------------

// File: rtl/p5_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p5_controller_if : start/IR-load inputs and datapath control bundle  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface p5_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;

  modport master (
    output s, load, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm5, sximm8
  );
endinterface
`default_nettype wire

// File: rtl/p5_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p5_controller : instruction register, decoder and Moore control FSM  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module p5_controller (
  input  logic           clk,
  input  logic           reset,
  p5_controller_if.slave bus
);
  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_COMPUTE   = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_mov_imm;
  logic       w_mov_reg;
  logic       w_mvn;
  logic       w_two_src;
  logic       w_cmp;

  assign w_opcode  = r_ir[15:13];
  assign w_op      = r_ir[12:11];
  assign w_rn      = r_ir[10:8];
  assign w_rd      = r_ir[7:5];
  assign w_sh      = r_ir[4:3];
  assign w_rm      = r_ir[2:0];

  assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
  assign w_two_src = (w_opcode == 3'b101) && (w_op != 2'b11);
  assign w_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);

  assign bus.sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
  assign bus.sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // IR only accepts a new word while idle, so an in-flight instruction is stable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= 16'h0000;
    end else if (bus.load && (r_state == S_WAIT)) begin
      r_ir <= bus.in;
    end
  end

  always_comb begin
    w_next = S_WAIT;
    case (r_state)
      S_WAIT:      w_next = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (w_mov_imm)                 w_next = S_WRITE_IMM;
        else if (w_mov_reg || w_mvn)   w_next = S_GET_B;
        else if (w_two_src)            w_next = S_GET_A;
        else                           w_next = S_WAIT;
      end
      S_WRITE_IMM: w_next = S_WAIT;
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_COMPUTE;
      S_COMPUTE:   w_next = w_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = 3'b000;
    bus.writenum = 3'b000;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = 2'b00;
    bus.shift    = w_sh;
    bus.ALUop    = w_op;
    case (r_state)
      S_WAIT:      bus.w = 1'b1;
      S_WRITE_IMM: begin
        bus.writenum = w_rn;
        bus.vsel     = 2'b01;
        bus.write    = 1'b1;
      end
      S_GET_A: begin
        bus.readnum = w_rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = w_rm;
        bus.loadb   = 1'b1;
      end
      S_COMPUTE: begin
        // MOV reg passes B through the adder with A forced to zero
        if (w_mov_reg) begin
          bus.ALUop = 2'b00;
          bus.asel  = 1'b1;
        end
        if (w_cmp) bus.loads = 1'b1;
        else       bus.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        bus.writenum = w_rd;
        bus.vsel     = 2'b00;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_p5_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_p5_controller : directed-vector bench for p5_controller           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_p5_controller;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic r_any_write;

  p5_controller_if bus ();

  p5_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // strobe vector {write, loada, loadb, loadc, loads}
  function automatic logic [4:0] strobes();
    return {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // load the word and pulse s together; returns sitting in DECODE
  task automatic start(input logic [15:0] instr);
    bus.in   = instr;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.s    = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    bus.s       = 1'b0;
    bus.load    = 1'b0;
    bus.in      = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    chk_eq("rst_w", {31'd0, bus.w}, 32'd1);
    chk_eq("rst_strobes", {27'd0, strobes()}, 32'd0);
    chk_eq("rst_sximm8", {16'd0, bus.sximm8}, 32'h0000);
    tick();
    chk_eq("idle_w", {31'd0, bus.w}, 32'd1);

    // MOV R1,#-2
    start(16'hD1FE);
    chk_eq("movi_decode_w", {31'd0, bus.w}, 32'd0);
    chk_eq("movi_decode_strobes", {27'd0, strobes()}, 32'd0);
    tick();
    chk_eq("movi_writenum", {29'd0, bus.writenum}, 32'd1);
    chk_eq("movi_vsel", {30'd0, bus.vsel}, 32'd1);
    chk_eq("movi_strobes", {27'd0, strobes()}, 32'b10000);
    chk_eq("movi_sximm8", {16'd0, bus.sximm8}, 32'hFFFE);
    chk_eq("movi_sximm5", {16'd0, bus.sximm5}, 32'hFFFE);
    tick();
    chk_eq("movi_done_w", {31'd0, bus.w}, 32'd1);

    // ADD R2,R1,R0,LSL#1 : load first, start on a later cycle
    bus.in   = 16'hA148;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk_eq("add_loaded_w", {31'd0, bus.w}, 32'd1);
    chk_eq("add_sximm5", {16'd0, bus.sximm5}, 32'h0008);
    bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    tick();
    chk_eq("add_geta_readnum", {29'd0, bus.readnum}, 32'd1);
    chk_eq("add_geta_strobes", {27'd0, strobes()}, 32'b01000);
    tick();
    chk_eq("add_getb_readnum", {29'd0, bus.readnum}, 32'd0);
    chk_eq("add_getb_strobes", {27'd0, strobes()}, 32'b00100);
    tick();
    chk_eq("add_comp_shift", {30'd0, bus.shift}, 32'd1);
    chk_eq("add_comp_aluop", {30'd0, bus.ALUop}, 32'd0);
    chk_eq("add_comp_asel", {31'd0, bus.asel}, 32'd0);
    chk_eq("add_comp_strobes", {27'd0, strobes()}, 32'b00010);
    tick();
    chk_eq("add_wr_writenum", {29'd0, bus.writenum}, 32'd2);
    chk_eq("add_wr_vsel", {30'd0, bus.vsel}, 32'd0);
    chk_eq("add_wr_strobes", {27'd0, strobes()}, 32'b10000);
    chk_eq("add_wr_w", {31'd0, bus.w}, 32'd0);
    tick();
    chk_eq("add_done_w", {31'd0, bus.w}, 32'd1);

    // CMP R1,R0
    start(16'hA900);
    r_any_write = bus.write;
    tick();
    r_any_write |= bus.write;
    chk_eq("cmp_geta_strobes", {27'd0, strobes()}, 32'b01000);
    tick();
    r_any_write |= bus.write;
    tick();
    r_any_write |= bus.write;
    chk_eq("cmp_comp_strobes", {27'd0, strobes()}, 32'b00001);
    chk_eq("cmp_comp_aluop", {30'd0, bus.ALUop}, 32'd1);
    tick();
    chk_eq("cmp_done_w", {31'd0, bus.w}, 32'd1);
    chk_eq("cmp_no_write", {31'd0, r_any_write}, 32'd0);

    // MOV R4,R0
    start(16'hC080);
    tick();
    chk_eq("movr_getb_strobes", {27'd0, strobes()}, 32'b00100);
    tick();
    chk_eq("movr_comp_asel", {31'd0, bus.asel}, 32'd1);
    chk_eq("movr_comp_aluop", {30'd0, bus.ALUop}, 32'd0);
    chk_eq("movr_comp_strobes", {27'd0, strobes()}, 32'b00010);
    tick();
    chk_eq("movr_wr_writenum", {29'd0, bus.writenum}, 32'd4);
    chk_eq("movr_wr_strobes", {27'd0, strobes()}, 32'b10000);
    tick();
    chk_eq("movr_done_w", {31'd0, bus.w}, 32'd1);

    // MVN R3,R0
    start(16'hB860);
    tick();
    chk_eq("mvn_getb_strobes", {27'd0, strobes()}, 32'b00100);
    tick();
    chk_eq("mvn_comp_aluop", {30'd0, bus.ALUop}, 32'd3);
    chk_eq("mvn_comp_asel", {31'd0, bus.asel}, 32'd0);
    tick();
    chk_eq("mvn_wr_writenum", {29'd0, bus.writenum}, 32'd3);
    tick();
    chk_eq("mvn_done_w", {31'd0, bus.w}, 32'd1);

    // load and s while busy must be ignored
    start(16'hA148);
    tick();
    tick();
    bus.in   = 16'hD007;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.s    = 1'b0;
    chk_eq("busy_comp_strobes", {27'd0, strobes()}, 32'b00010);
    tick();
    chk_eq("busy_wr_writenum", {29'd0, bus.writenum}, 32'd2);
    tick();
    chk_eq("busy_done_w", {31'd0, bus.w}, 32'd1);
    chk_eq("busy_ir_kept", {16'd0, bus.sximm8}, 32'h0048);
    tick();
    chk_eq("busy_no_requeue_w", {31'd0, bus.w}, 32'd1);
    chk_eq("busy_no_requeue_strobes", {27'd0, strobes()}, 32'd0);

    // illegal opcode
    start(16'hE000);
    chk_eq("ill_decode_strobes", {27'd0, strobes()}, 32'd0);
    chk_eq("ill_decode_w", {31'd0, bus.w}, 32'd0);
    tick();
    chk_eq("ill_done_w", {31'd0, bus.w}, 32'd1);
    chk_eq("ill_done_strobes", {27'd0, strobes()}, 32'd0);

    // reset in the middle of an ADD
    start(16'hA148);
    tick();
    tick();
    chk_eq("mrst_getb_strobes", {27'd0, strobes()}, 32'b00100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_eq("mrst_w", {31'd0, bus.w}, 32'd1);
    chk_eq("mrst_strobes", {27'd0, strobes()}, 32'd0);
    chk_eq("mrst_sximm8", {16'd0, bus.sximm8}, 32'h0000);
    tick();
    chk_eq("mrst_after_w", {31'd0, bus.w}, 32'd1);
    chk_eq("mrst_after_strobes", {27'd0, strobes()}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
